// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel toggles clk_out and pulses tick
// every div_a+1 enabled cycles, with pending divide values applied glitch-free at the wrap.
module clk_div_multi #(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned CNT_W    = 27,
  parameter int unsigned DIV_INIT = 49999999
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  logic [N_CH-1:0][CNT_W-1:0] r_div_a;
  logic [N_CH-1:0][CNT_W-1:0] r_div_p;
  logic [N_CH-1:0][CNT_W-1:0] r_cnt;
  logic [N_CH-1:0]            r_clk;
  logic [N_CH-1:0]            r_tick;

  logic [N_CH-1:0][CNT_W-1:0] w_div_a;
  logic [N_CH-1:0][CNT_W-1:0] w_div_p;
  logic [N_CH-1:0][CNT_W-1:0] w_cnt;
  logic [N_CH-1:0]            w_clk;
  logic [N_CH-1:0]            w_tick;
  logic [N_CH-1:0]            w_wr;

  always_comb begin
    w_div_a = r_div_a;
    w_div_p = r_div_p;
    w_cnt   = r_cnt;
    w_clk   = r_clk;
    w_tick  = '0;
    w_wr    = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_wr[i] = cfg_we && (cfg_ch == 3'(i));
      if (w_wr[i]) begin
        w_div_p[i] = cfg_div;
      end
      if (sync) begin
        // A write in the same cycle as sync lands in div_a directly.
        w_cnt[i]   = '0;
        w_clk[i]   = 1'b0;
        w_div_a[i] = w_div_p[i];
      end else if (r_div_a[i] == '0) begin
        w_cnt[i] = '0;
        w_clk[i] = 1'b0;
        if (en) begin
          w_div_a[i] = r_div_p[i];
        end
      end else if (en) begin
        if (r_cnt[i] == r_div_a[i]) begin
          w_cnt[i]   = '0;
          w_tick[i]  = 1'b1;
          w_div_a[i] = r_div_p[i];
          // Disabling at a wrap parks the output low instead of toggling.
          w_clk[i]   = (r_div_p[i] == '0) ? 1'b0 : ~r_clk[i];
        end else begin
          w_cnt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_div_a <= {N_CH{CNT_W'(DIV_INIT)}};
      r_div_p <= {N_CH{CNT_W'(DIV_INIT)}};
      r_cnt   <= '0;
      r_clk   <= '0;
      r_tick  <= '0;
    end else begin
      r_div_a <= w_div_a;
      r_div_p <= w_div_p;
      r_cnt   <= w_cnt;
      r_clk   <= w_clk;
      r_tick  <= w_tick;
    end
  end

  assign clk_out = r_clk;
  assign tick    = r_tick;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: expected per-cycle outputs are queued when stimulus is
// driven and popped/compared as the DUT advances past each rising edge.
module tb_clk_div_multi;

  logic       clk_in;
  logic       reset;
  logic       en;
  logic       sync;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [1:0] clk_out;
  logic [1:0] tick;

  clk_div_multi #(
    .N_CH    (2),
    .CNT_W   (8),
    .DIV_INIT(3)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .en     (en),
    .sync   (sync),
    .cfg_we (cfg_we),
    .cfg_ch (cfg_ch),
    .cfg_div(cfg_div),
    .clk_out(clk_out),
    .tick   (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int         cyc;
    logic [1:0] tk;
    logic [1:0] ck;
    logic [1:0] tm;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic push(input int cyc, input logic [1:0] tk, input logic [1:0] ck,
                      input logic [1:0] tm, input string tag);
    exp_t e;
    e.cyc = cyc;
    e.tk  = tk;
    e.ck  = ck;
    e.tm  = tm;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_run(input int cyc, input int n, input logic [1:0] tk,
                          input logic [1:0] ck, input string tag);
    for (int j = 0; j < n; j++) push(cyc + j, tk, ck, 2'b11, tag);
  endtask

  // Advance one edge, then compare every expectation due on this cycle.
  task automatic step();
    exp_t e;
    @(posedge clk_in);
    #1;
    cyc_n++;
    while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
      e = sb.pop_front();
      chk({e.tag, "_tick"}, tick & e.tm, e.tk & e.tm);
      chk({e.tag, "_clk"}, clk_out, e.ck);
    end
  endtask

  int b, c, s, t, r;

  initial begin
    reset   = 1'b0;
    en      = 1'b0;
    sync    = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = 3'd0;
    cfg_div = 8'd0;
    step();
    step();
    chk("reset_tick", tick, 2'b00);
    chk("reset_clk", clk_out, 2'b00);

    // Basic divide, D=3 from reset: tick every 4, clk period 8, channels in phase.
    reset = 1'b1;
    en    = 1'b1;
    b     = cyc_n;
    for (int k = 1; k <= 16; k++)
      push(b + k, (k % 4 == 0) ? 2'b11 : 2'b00, ((k / 4) % 2 == 1) ? 2'b11 : 2'b00, 2'b11,
           "basic");
    repeat (16) step();

    // Retune ch1 to D=1 while its cnt is 1.
    push(cyc_n + 1, 2'b00, 2'b00, 2'b11, "pre_retune");
    step();
    c = cyc_n;
    for (int k = 1; k <= 12; k++)
      push(c + k,
           {(k >= 3) && (k % 2 == 1), (k >= 3) && ((k - 3) % 4 == 0)},
           {(k >= 3) && (((k - 3) / 2) % 2 == 0), (k >= 3) && (((k - 3) / 4) % 2 == 0)},
           2'b11, "retune");
    cfg_we  = 1'b1;
    cfg_ch  = 3'd1;
    cfg_div = 8'd1;
    step();
    cfg_we = 1'b0;
    repeat (11) step();

    // Sync with write to ch1 (D=3) realigns, then freeze for 5 cycles mid-period.
    s = cyc_n + 1;
    push(s, 2'b00, 2'b00, 2'b11, "sync_a");
    push_run(s + 1, 3, 2'b00, 2'b00, "freeze_pre");
    push(s + 4, 2'b11, 2'b11, 2'b11, "freeze_wrap");
    push_run(s + 5, 8, 2'b00, 2'b11, "freeze_hold");
    push(s + 13, 2'b11, 2'b00, 2'b11, "freeze_resume");
    push(s + 14, 2'b00, 2'b00, 2'b11, "freeze_post");
    sync    = 1'b1;
    cfg_we  = 1'b1;
    cfg_ch  = 3'd1;
    cfg_div = 8'd3;
    step();
    sync   = 1'b0;
    cfg_we = 1'b0;
    repeat (6) step();
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    repeat (3) step();

    // Disable ch0 (D=0) then re-enable with D=2.
    push_run(s + 15, 2, 2'b00, 2'b00, "dis_pre");
    push(s + 17, 2'b10, 2'b10, 2'b10, "dis_wrap");
    push_run(s + 18, 3, 2'b00, 2'b10, "dis_off");
    push(s + 21, 2'b10, 2'b00, 2'b11, "en_load");
    push_run(s + 22, 2, 2'b00, 2'b00, "en_count");
    push(s + 24, 2'b01, 2'b01, 2'b11, "en_first_tick");
    push(s + 25, 2'b10, 2'b11, 2'b11, "en_run");
    push(s + 26, 2'b00, 2'b11, 2'b11, "en_run");
    push(s + 27, 2'b01, 2'b10, 2'b11, "en_run");
    push(s + 28, 2'b00, 2'b10, 2'b11, "en_run");
    cfg_we  = 1'b1;
    cfg_ch  = 3'd0;
    cfg_div = 8'd0;
    step();
    cfg_we = 1'b0;
    repeat (4) step();
    cfg_we  = 1'b1;
    cfg_div = 8'd2;
    step();
    cfg_we = 1'b0;
    repeat (8) step();

    // ch0 pending D=5, then sync with simultaneous ch1 write D=7; later an out-of-range write.
    push(s + 29, 2'b10, 2'b00, 2'b11, "pre_sync");
    t = cyc_n + 2;
    push(t, 2'b00, 2'b00, 2'b11, "sync_b");
    for (int k = 1; k <= 40; k++)
      push(t + k, {k % 8 == 0, k % 6 == 0}, {(k / 8) % 2 == 1, (k / 6) % 2 == 1}, 2'b11,
           "sync_run");
    cfg_we  = 1'b1;
    cfg_ch  = 3'd0;
    cfg_div = 8'd5;
    step();
    sync    = 1'b1;
    cfg_ch  = 3'd1;
    cfg_div = 8'd7;
    step();
    sync   = 1'b0;
    cfg_we = 1'b0;
    repeat (24) step();
    cfg_we  = 1'b1;
    cfg_ch  = 3'd5;
    cfg_div = 8'd1;
    step();
    cfg_we = 1'b0;
    repeat (15) step();

    // Asynchronous reset between edges, then restart from DIV_INIT.
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_tick", tick, 2'b00);
    chk("async_rst_clk", clk_out, 2'b00);
    push(cyc_n + 1, 2'b00, 2'b00, 2'b11, "rst_held");
    step();
    reset = 1'b1;
    r     = cyc_n;
    for (int k = 1; k <= 8; k++)
      push(r + k, (k % 4 == 0) ? 2'b11 : 2'b00, (k >= 4 && k < 8) ? 2'b11 : 2'b00, 2'b11,
           "post_rst");
    repeat (8) step();

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
